// File: rtl/eeg_frame_assembler.sv
// rtl/eeg_frame_assembler.sv - ping-pong frame assembler feeding the seizure classifier
// Two banks cycle FREE -> READY -> ISSUED -> FREE; the issued bank is held until release.
module eeg_frame_assembler #(
  parameter int DATA_WIDTH    = 16,
  parameter int FEATURE_COUNT = 178,
  parameter int HOLD_TIMEOUT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  frame_start,
  input  logic                  downstream_ready,
  output logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] eeg_data [FEATURE_COUNT-1:0],
  output logic                  data_valid,
  output logic                  frame_busy,
  output logic [7:0]            fill_level,
  output logic [7:0]            overflow_cnt
);

  typedef enum logic [1:0] {FREE = 2'd0, READY = 2'd1, ISSUED = 2'd2} bank_state_t;

  localparam logic [7:0] LAST_IDX  = 8'(FEATURE_COUNT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TIMEOUT - 1);

  logic [DATA_WIDTH-1:0] mem0 [FEATURE_COUNT-1:0];
  logic [DATA_WIDTH-1:0] mem1 [FEATURE_COUNT-1:0];

  bank_state_t st0, st1;
  logic        wr_bank, rd_next, rd_bank, seen_low;
  logic [7:0]  wr_idx, hold_cnt;

  logic       wr_free, accept, complete, next_ready, any_issued, issue, release_now;
  logic [7:0] wr_pos;

  assign wr_free    = wr_bank ? (st1 == FREE) : (st0 == FREE);
  assign accept     = sample_valid && wr_free;
  // A resync sample lands at index 0; frame_start only matters when a write can happen.
  assign wr_pos     = frame_start ? 8'd0 : wr_idx;
  assign complete   = accept && (wr_pos == LAST_IDX);
  assign next_ready = rd_next ? (st1 == READY) : (st0 == READY);
  assign any_issued = (st0 == ISSUED) || (st1 == ISSUED);
  assign issue      = next_ready && downstream_ready && !any_issued;
  // Release on ready returning after a low, or on timeout if ready never dropped.
  assign release_now = any_issued && downstream_ready && (seen_low || hold_cnt == HOLD_LAST);

  assign sample_ready = wr_free;
  assign frame_busy   = any_issued;
  assign fill_level   = wr_idx;

  always_comb begin
    for (int i = 0; i < FEATURE_COUNT; i++) begin
      eeg_data[i] = rd_bank ? mem1[i] : mem0[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0          <= FREE;
      st1          <= FREE;
      wr_bank      <= 1'b0;
      rd_next      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_idx       <= 8'd0;
      seen_low     <= 1'b0;
      hold_cnt     <= 8'd0;
      data_valid   <= 1'b0;
      overflow_cnt <= 8'd0;
      for (int i = 0; i < FEATURE_COUNT; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      data_valid <= issue;

      if (accept) begin
        if (wr_bank) mem1[wr_pos] <= sample_in;
        else         mem0[wr_pos] <= sample_in;
        wr_idx <= complete ? 8'd0 : wr_pos + 8'd1;
      end else if (frame_start && wr_free) begin
        wr_idx <= 8'd0;
      end

      if (sample_valid && !wr_free && overflow_cnt != 8'hFF) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end

      // The three transitions always target banks in different states, so they never collide.
      if (complete) begin
        if (wr_bank) st1 <= READY;
        else         st0 <= READY;
        wr_bank <= ~wr_bank;
      end
      if (issue) begin
        if (rd_next) st1 <= ISSUED;
        else         st0 <= ISSUED;
        rd_bank  <= rd_next;
        rd_next  <= ~rd_next;
        seen_low <= 1'b0;
        hold_cnt <= 8'd0;
      end else if (any_issued) begin
        if (!downstream_ready) seen_low <= 1'b1;
        if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
      end
      if (release_now) begin
        if (rd_bank) st1 <= FREE;
        else         st0 <= FREE;
      end
    end
  end

endmodule
